// File: rtl/sim_video_palette_out.sv
// rtl/sim_video_palette_out.sv - palette-based video output stage
// Index -> RGB lookup with runtime-loadable palette and a 2-stage ce_pix pipeline.
module sim_video_palette_out #(
  parameter int         BPP       = 1,
  parameter int         OUT_W     = 8,
  parameter logic [7:0] PAL_INDEX = 8'h02
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce_pix,
  input  logic [BPP-1:0]   pix,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             hblank_in,
  input  logic             vblank_in,
  input  logic             ioctl_download,
  input  logic             ioctl_wr,
  input  logic [24:0]      ioctl_addr,
  input  logic [7:0]       ioctl_dout,
  input  logic [7:0]       ioctl_index,
  output logic [OUT_W-1:0] VGA_R,
  output logic [OUT_W-1:0] VGA_G,
  output logic [OUT_W-1:0] VGA_B,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             VGA_HB,
  output logic             VGA_VB,
  output logic             frame_start
);

  localparam int NENT   = 1 << BPP;
  localparam int NBYTES = 3 * NENT;

  if (!(BPP == 1 || BPP == 2 || BPP == 4 || BPP == 8) || OUT_W < 1 || OUT_W > 8) begin : g_bad_param
    $error("sim_video_palette_out: illegal BPP or OUT_W");
  end

  function automatic logic [23:0] default_entry(input int i);
    logic [7:0] g;
    g = {(8 / BPP){i[BPP-1:0]}};
    return {g, g, g};
  endfunction

  logic [23:0]    pal_q [NENT];
  logic           wr_en;
  logic [9:0]     addr_lo;
  logic [BPP-1:0] wr_entry;
  logic [1:0]     wr_byte;

  assign addr_lo  = ioctl_addr[9:0];
  assign wr_en    = ioctl_download & ioctl_wr & (ioctl_index == PAL_INDEX) &
                    (ioctl_addr < 25'(NBYTES));
  assign wr_entry = BPP'(addr_lo / 10'd3);
  assign wr_byte  = 2'(addr_lo % 10'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NENT; i++) pal_q[i] <= default_entry(i);
    end else if (wr_en) begin
      case (wr_byte)
        2'd0:    pal_q[wr_entry][23:16] <= ioctl_dout;
        2'd1:    pal_q[wr_entry][15:8]  <= ioctl_dout;
        default: pal_q[wr_entry][7:0]   <= ioctl_dout;
      endcase
    end
  end

  // sync bit order everywhere: {hs, vs, hb, vb}
  logic [BPP-1:0] s1_pix_q, s1_pix_d;
  logic [3:0]     s1_sync_q, s1_sync_d;
  logic           s1_vis_q, s1_vis_d;
  logic [23:0]    s2_rgb_q, s2_rgb_d;
  logic [3:0]     s2_sync_q, s2_sync_d;
  logic           armed_q, armed_d;
  logic           fs_q, fs_d;
  logic           fire;

  always_comb begin
    s1_pix_d  = s1_pix_q;
    s1_sync_d = s1_sync_q;
    s1_vis_d  = s1_vis_q;
    s2_rgb_d  = s2_rgb_q;
    s2_sync_d = s2_sync_q;
    armed_d   = armed_q;
    fs_d      = 1'b0;
    fire      = 1'b0;
    if (ce_pix) begin
      s1_pix_d  = pix;
      s1_sync_d = {hsync_in, vsync_in, hblank_in, vblank_in};
      s1_vis_d  = ~hblank_in & ~vblank_in;
      // palette read sees pre-write contents, so a same-cycle write shows up next time
      s2_rgb_d  = s1_vis_q ? pal_q[s1_pix_q] : 24'h0;
      s2_sync_d = s1_sync_q;
      fire      = armed_q & s1_vis_q;
      fs_d      = fire;
      armed_d   = (armed_q & ~fire) | vblank_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_pix_q  <= '0;
      s1_sync_q <= '0;
      s1_vis_q  <= 1'b0;
      s2_rgb_q  <= '0;
      s2_sync_q <= '0;
      armed_q   <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      s1_pix_q  <= s1_pix_d;
      s1_sync_q <= s1_sync_d;
      s1_vis_q  <= s1_vis_d;
      s2_rgb_q  <= s2_rgb_d;
      s2_sync_q <= s2_sync_d;
      armed_q   <= armed_d;
      fs_q      <= fs_d;
    end
  end

  assign VGA_R       = s2_rgb_q[23 -: OUT_W];
  assign VGA_G       = s2_rgb_q[15 -: OUT_W];
  assign VGA_B       = s2_rgb_q[7 -: OUT_W];
  assign VGA_HS      = s2_sync_q[3];
  assign VGA_VS      = s2_sync_q[2];
  assign VGA_HB      = s2_sync_q[1];
  assign VGA_VB      = s2_sync_q[0];
  assign frame_start = fs_q;

endmodule

// File: doc/sim_video_palette_out.md
Name: sim_video_palette_out

Overview:
- Parametrised video output stage for the Verilator top and for future cores. It generalises the fixed 1bpp-to-8bpp white/black expansion.
- Takes BPP-bit pixel indices plus raw sync/blank signals from the core.
- Looks each index up in a 2^BPP-entry RGB palette, which can be loaded at runtime through the ioctl download channel.
- Outputs OUT_W-bit RGB together with sync/blank, all delayed by the same pipeline latency so they stay aligned.
- Sits between the core's video outputs and the VGA_* ports of the top.

Parameters:
- BPP, 1, pixel index width; legal values are 1, 2, 4 and 8 (any other value is an elaboration error).
- OUT_W, 8, width of each output colour channel; legal range 1..8.
- PAL_INDEX, 8'h02, ioctl_index value that selects a palette download.

Ports:
- clk  in  1  core clock (clk_48 at the top).
- reset  in  1  asynchronous, active-high reset.
- ce_pix  in  1  pixel clock enable; the pipeline advances only when it is 1.
- pix  in  BPP  pixel palette index from the core.
- hsync_in  in  1  raw horizontal sync.
- vsync_in  in  1  raw vertical sync.
- hblank_in  in  1  raw horizontal blank.
- vblank_in  in  1  raw vertical blank.
- ioctl_download  in  1  download active.
- ioctl_wr  in  1  download byte strobe.
- ioctl_addr  in  25  download byte address.
- ioctl_dout  in  8  download byte.
- ioctl_index  in  8  download target selector.
- VGA_R, VGA_G, VGA_B  out  OUT_W each  colour channels.
- VGA_HS, VGA_VS, VGA_HB, VGA_VB  out  1 each  aligned sync and blank.
- frame_start  out  1  one-cycle pulse on the first visible pixel of each frame.

Behaviour:
- Reset (asynchronous, active-high):
  - all outputs go to 0;
  - pipeline registers are cleared;
  - the palette reloads its defaults.
- Default palette: entry i is grey, with R=G=B={8/BPP copies of i}. For BPP=1 this gives entry 0 = 00 and entry 1 = FF, which matches the legacy behaviour.
- Palette storage: 2^BPP entries x 24 bits (R[23:16], G[15:8], B[7:0]), held in flops.
- Palette write:
  - Condition: ioctl_download & ioctl_wr & (ioctl_index==PAL_INDEX) & (ioctl_addr < 3*2^BPP).
  - Target entry = ioctl_addr/3; byte = ioctl_addr%3, where 0=R, 1=G, 2=B.
  - Out-of-range addresses and other ioctl_index values are ignored.
  - Writes are independent of ce_pix.
- Pipeline, 2 ce_pix-qualified stages; latency is exactly 2 enabled cycles:
  - S1: register pix and the four sync/blank inputs. Also compute visible = ~hblank_in & ~vblank_in.
  - S2: register palette[S1.pix]. Force RGB to 0 when S1 is not visible. Pass the sync/blank bits through.
- Output truncation: each channel outputs the top OUT_W bits of its 8-bit palette byte.
- Read/write collision: when a palette write and an S2 lookup hit the same entry in the same cycle, the lookup returns the old value. The new value is visible from the next enabled cycle.
- ce_pix=0: all pipeline registers and outputs hold their values.
- frame_start:
  - Asserted for exactly one clk cycle, in the cycle where S2 loads the first visible pixel after vblank_in has been seen high.
  - An internal flag arms it when vblank is seen high, and the pulse clears the flag.
  - The pulse is not raised again until vblank has been high once more.
  - After reset the flag is clear, so no pulse occurs until a vblank has been observed.
- Reset in mid-line: all outputs drop to 0 asynchronously. The first valid output appears 2 enabled cycles after reset is released.
- Download in progress: video continues; only the palette entries being written change.

Test Plan:
1. Reset, BPP=1, OUT_W=8, ce_pix=1, blank low. Drive pix=1 at cycle 0 -> VGA_R/G/B=FF at cycle 2. Drive pix=0 -> 00 two cycles later.
2. BPP=4, reset, pix=4'h5 -> RGB=55 each. Then set hblank_in=1 with pix=4'hF -> RGB=00 and VGA_HB=1, both 2 cycles after the input change.
3. BPP=2, PAL_INDEX download of bytes 12,34,56 at addr 3..5 -> entry 1 = 123456. Then pix=1 -> R=12, G=34, B=56. A write at addr 12 leaves all entries unchanged.
4. Toggle ce_pix 1,0,0,1,1 with a pix change on the first enable -> output changes only on the third enabled cycle, i.e. after 2 enables. Outputs hold during the ce_pix=0 cycles.
5. Sequence vblank 1->0 with hblank 0 -> frame_start pulses once, 1 clk wide, aligned with the first visible pixel output. No pulse occurs on later lines of the same frame.
6. Assert reset asynchronously mid-line between clk edges -> all outputs read 0 immediately. A previously downloaded entry 1 reverts to the default grey.
